// File: rtl/tmds_period_arbiter.sv
// tmds_period_arbiter
//
// Purpose
//   Decides, character by character, what the three TMDS lanes carry in each
//   HDMI period. The choices are control characters, the video preamble, the
//   video guard band, active video, or data-island characters.
//   Every source signal runs through a LOOKAHEAD-deep delay line. The raw
//   dataEnable therefore acts as an early warning. Its rising edge arrives
//   10 cycles before the delayed video does, which leaves room to insert
//   8 preamble characters and 2 guard characters in front of the line.
//
// Ports
//   pixelClock       pixel-rate clock; all state updates on the rising edge
//   reset            synchronous, active-high
//   hSync, vSync     raw sync levels, aligned with dataEnable
//   dataEnable       raw active-video flag, used undelayed as lookahead
//   videoCh0..2      TMDS-encoded video characters
//   hIslandActive    horizontal-blanking data island flag; hCh0..2 its characters
//   vIslandActive    vertical-blanking data island flag; vCh0..2 its characters
//   tmdsCh0..2       registered output characters (11 cycles input-to-output)
//   collisionError   sticky; source overlap or short-blanking violation

module tmds_period_arbiter #(
    parameter int LOOKAHEAD = 10
) (
    input  logic       pixelClock,
    input  logic       reset,
    input  logic       hSync,
    input  logic       vSync,
    input  logic       dataEnable,
    input  logic [9:0] videoCh0,
    input  logic [9:0] videoCh1,
    input  logic [9:0] videoCh2,
    input  logic       hIslandActive,
    input  logic [9:0] hCh0,
    input  logic [9:0] hCh1,
    input  logic [9:0] hCh2,
    input  logic       vIslandActive,
    input  logic [9:0] vCh0,
    input  logic [9:0] vCh1,
    input  logic [9:0] vCh2,
    output logic [9:0] tmdsCh0,
    output logic [9:0] tmdsCh1,
    output logic [9:0] tmdsCh2,
    output logic       collisionError
);

    localparam logic [1:0] ST_CTRL  = 2'd0;
    localparam logic [1:0] ST_PRE   = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;
    localparam logic [1:0] ST_VIDEO = 2'd3;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;
    localparam logic [9:0] GUARD_A = 10'b1011001100;
    localparam logic [9:0] GUARD_B = 10'b0100110011;

    // Layout of one delay-line word.
    localparam int HS_BIT  = 0;
    localparam int VS_BIT  = 1;
    localparam int DE_BIT  = 2;
    localparam int HI_BIT  = 3;
    localparam int VI_BIT  = 4;
    localparam int VID_LSB = 5;
    localparam int H_LSB   = 35;
    localparam int V_LSB   = 65;
    localparam int W       = 95;

    function automatic logic [9:0] ctrl_char(input logic [1:0] sel);
        logic [9:0] c;
        case (sel)
            2'b00:   c = CTRL_00;
            2'b01:   c = CTRL_01;
            2'b10:   c = CTRL_10;
            default: c = CTRL_11;
        endcase
        return c;
    endfunction

    logic [LOOKAHEAD-1:0][W-1:0] pipe_q, pipe_d;
    logic [W-1:0]                in_bus;
    logic [W-1:0]                tap;
    logic [1:0]                  state_q, state_d;
    logic [2:0]                  cnt_q, cnt_d;
    logic [9:0]                  ch0_q, ch0_d, ch1_q, ch1_d, ch2_q, ch2_d;
    logic                        collision_q, collision_d;

    logic        hs_dly, vs_dly, de_dly, hi_dly, vi_dly;
    logic [29:0] video_dly, h_dly, v_dly;
    logic        de_prev, de_rise, de_recent, ctrl_eff, start;

    assign in_bus = {vCh2, vCh1, vCh0, hCh2, hCh1, hCh0,
                     videoCh2, videoCh1, videoCh0,
                     vIslandActive, hIslandActive, dataEnable, vSync, hSync};

    assign tap       = pipe_q[LOOKAHEAD-1];
    assign hs_dly    = tap[HS_BIT];
    assign vs_dly    = tap[VS_BIT];
    assign de_dly    = tap[DE_BIT];
    assign hi_dly    = tap[HI_BIT];
    assign vi_dly    = tap[VI_BIT];
    assign video_dly = tap[VID_LSB +: 30];
    assign h_dly     = tap[H_LSB +: 30];
    assign v_dly     = tap[V_LSB +: 30];

    // The first delay stage doubles as the previous raw dataEnable sample.
    assign de_prev = pipe_q[0][DE_BIT];
    assign de_rise = dataEnable & ~de_prev;

    // Shift the delay line by one word per pixel.
    always_comb begin
        pipe_d = {pipe_q[LOOKAHEAD-2:0], in_bus};
    end

    // A rise only earns a preamble when the whole delay line holds blanking.
    // Otherwise fewer than 10 blanking characters remain to carry it.
    always_comb begin
        de_recent = 1'b0;
        for (int i = 0; i < LOOKAHEAD; i++) begin
            de_recent = de_recent | pipe_q[i][DE_BIT];
        end
    end

    // VIDEO whose delayed dataEnable has just dropped leaves this cycle.
    // It counts as CTRL here, so a rise that follows exactly 10 blanking
    // cycles still qualifies.
    assign ctrl_eff = (state_q == ST_CTRL) | ((state_q == ST_VIDEO) & ~de_dly);
    assign start    = de_rise & ctrl_eff & ~de_recent;

    // Next-state logic. Delayed active video always wins and forces VIDEO.
    // PRE and GUARD run their full length even if raw dataEnable drops.
    // state_d describes the character being chosen this cycle, so the output
    // register follows it directly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (de_dly) begin
            state_d = ST_VIDEO;
            cnt_d   = 3'd0;
        end else if (start) begin
            state_d = ST_PRE;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                ST_PRE: begin
                    if (cnt_q == 3'd7) begin
                        state_d = ST_GUARD;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                ST_GUARD: begin
                    if (cnt_q == 3'd1) begin
                        state_d = ST_VIDEO;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_d = ST_CTRL;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    // Character selection: VIDEO > GUARD > PRE > h island > v island > control.
    always_comb begin
        ch0_d = CTRL_00;
        ch1_d = CTRL_00;
        ch2_d = CTRL_00;
        case (state_d)
            ST_VIDEO: begin
                {ch2_d, ch1_d, ch0_d} = video_dly;
            end
            ST_GUARD: begin
                ch0_d = GUARD_A;
                ch1_d = GUARD_B;
                ch2_d = GUARD_A;
            end
            ST_PRE: begin
                ch0_d = ctrl_char({vs_dly, hs_dly});
                ch1_d = CTRL_01;
                ch2_d = CTRL_00;
            end
            default: begin
                if (hi_dly) begin
                    {ch2_d, ch1_d, ch0_d} = h_dly;
                end else if (vi_dly) begin
                    {ch2_d, ch1_d, ch0_d} = v_dly;
                end else begin
                    ch0_d = ctrl_char({vs_dly, hs_dly});
                end
            end
        endcase
    end

    // Island flags are checked against the delayed timeline. A premature or
    // short-blanking rise is flagged as soon as it is seen on raw dataEnable.
    always_comb begin
        collision_d = collision_q
                    | (hi_dly & vi_dly)
                    | ((hi_dly | vi_dly) & (state_d != ST_CTRL))
                    | (de_rise & ~start);
    end

    always_ff @(posedge pixelClock) begin
        if (reset) begin
            pipe_q      <= '0;
            state_q     <= ST_CTRL;
            cnt_q       <= 3'd0;
            ch0_q       <= CTRL_00;
            ch1_q       <= CTRL_00;
            ch2_q       <= CTRL_00;
            collision_q <= 1'b0;
        end else begin
            pipe_q      <= pipe_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ch0_q       <= ch0_d;
            ch1_q       <= ch1_d;
            ch2_q       <= ch2_d;
            collision_q <= collision_d;
        end
    end

    assign tmdsCh0        = ch0_q;
    assign tmdsCh1        = ch1_q;
    assign tmdsCh2        = ch2_q;
    assign collisionError = collision_q;

endmodule

// File: tb/tb_tmds_period_arbiter.sv
// tb_tmds_period_arbiter
//
// Purpose
//   Drives tmds_period_arbiter with directed and randomised blanking/video/
//   island sequences. The expected output stream comes from a slot-based
//   reference model, and a monitor compares every output cycle against it.
//
// Model idea
//   Input cycle k produces output character k, which appears 11 cycles later.
//   A qualified dataEnable rise at cycle n rewrites slots n-10..n-1 into
//   8 preamble characters and 2 guard characters. A rise qualifies when the
//   ten raw dataEnable samples before it were all 0.
//   Any other slot shows video when its own dataEnable is 1. Otherwise it
//   shows island data or control characters.

module tb_tmds_period_arbiter;

    localparam int         HIST    = 8192;
    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;
    localparam logic [9:0] GUARD_A = 10'b1011001100;
    localparam logic [9:0] GUARD_B = 10'b0100110011;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        hi;
        logic        vi;
        logic [29:0] video;
        logic [29:0] hch;
        logic [29:0] vch;
    } in_t;

    typedef struct packed {
        logic [29:0] chars;
        logic        coll;
    } exp_t;

    logic       pixelClock = 1'b0;
    logic       reset;
    logic       hSync, vSync, dataEnable, hIslandActive, vIslandActive;
    logic [9:0] videoCh0, videoCh1, videoCh2;
    logic [9:0] hCh0, hCh1, hCh2, vCh0, vCh1, vCh2;
    logic [9:0] tmdsCh0, tmdsCh1, tmdsCh2;
    logic       collisionError;

    in_t  hist [HIST];
    int   ovr  [HIST];
    int   cyc;
    logic collSticky;
    exp_t expQ [$];
    exp_t mon;
    int   checks;
    int   passes;

    tmds_period_arbiter #(.LOOKAHEAD(10)) dut (
        .pixelClock    (pixelClock),
        .reset         (reset),
        .hSync         (hSync),
        .vSync         (vSync),
        .dataEnable    (dataEnable),
        .videoCh0      (videoCh0),
        .videoCh1      (videoCh1),
        .videoCh2      (videoCh2),
        .hIslandActive (hIslandActive),
        .hCh0          (hCh0),
        .hCh1          (hCh1),
        .hCh2          (hCh2),
        .vIslandActive (vIslandActive),
        .vCh0          (vCh0),
        .vCh1          (vCh1),
        .vCh2          (vCh2),
        .tmdsCh0       (tmdsCh0),
        .tmdsCh1       (tmdsCh1),
        .tmdsCh2       (tmdsCh2),
        .collisionError(collisionError)
    );

    // Free-running pixel clock.
    always #5 pixelClock = ~pixelClock;

    function automatic logic [9:0] ctrlChar(input logic [1:0] sel);
        logic [9:0] c;
        case (sel)
            2'b00:   c = CTRL_00;
            2'b01:   c = CTRL_01;
            2'b10:   c = CTRL_10;
            default: c = CTRL_11;
        endcase
        return c;
    endfunction

    // Reset clears everything still inside the DUT's delay line. The output
    // after a reset edge is control 00 on all lanes, with no error.
    task automatic modelReset();
        for (int j = 0; j <= 10; j++) begin
            hist[cyc-j] = '0;
            ovr[cyc-j]  = 0;
        end
        collSticky = 1'b0;
        expQ.push_back({{CTRL_00, CTRL_00, CTRL_00}, 1'b0});
    endtask

    // Record input cycle cyc, apply any preamble it triggers, then settle
    // slot cyc-10, which becomes visible after this clock edge.
    task automatic modelStep(input in_t s);
        int          k;
        logic        quiet;
        in_t         o;
        logic [29:0] chars;
        hist[cyc] = s;
        if (s.de && !hist[cyc-1].de) begin
            quiet = 1'b1;
            for (int j = 1; j <= 10; j++) begin
                if (hist[cyc-j].de) quiet = 1'b0;
            end
            if (quiet) begin
                for (int j = 0; j < 10; j++) ovr[cyc-10+j] = j + 1;
            end else begin
                collSticky = 1'b1;
            end
        end
        k = cyc - 10;
        o = hist[k];
        if (o.de)            chars = o.video;
        else if (ovr[k] >= 9) chars = {GUARD_A, GUARD_B, GUARD_A};
        else if (ovr[k] >= 1) chars = {CTRL_00, CTRL_01, ctrlChar({o.vs, o.hs})};
        else if (o.hi)        chars = o.hch;
        else if (o.vi)        chars = o.vch;
        else                  chars = {CTRL_00, CTRL_00, ctrlChar({o.vs, o.hs})};
        if ((o.hi && o.vi) || ((o.hi || o.vi) && (o.de || ovr[k] != 0)))
            collSticky = 1'b1;
        expQ.push_back({chars, collSticky});
    endtask

    // One input cycle: drive the DUT at the falling edge and update the model.
    task automatic applyStimulus(input in_t s, input logic rst);
        @(negedge pixelClock);
        reset         = rst;
        hSync         = s.hs;
        vSync         = s.vs;
        dataEnable    = s.de;
        hIslandActive = s.hi;
        vIslandActive = s.vi;
        {videoCh2, videoCh1, videoCh0} = s.video;
        {hCh2, hCh1, hCh0}             = s.hch;
        {vCh2, vCh1, vCh0}             = s.vch;
        if (rst) modelReset();
        else     modelStep(s);
        cyc++;
    endtask

    function automatic in_t mkIn(logic de, logic hs, logic vs, logic hi, logic vi);
        in_t s;
        s.de    = de;
        s.hs    = hs;
        s.vs    = vs;
        s.hi    = hi;
        s.vi    = vi;
        s.video = 30'($urandom());
        s.hch   = 30'($urandom());
        s.vch   = 30'($urandom());
        return s;
    endfunction

    task automatic blank(input int n, input logic hs, input logic vs,
                         input logic hi, input logic vi);
        for (int i = 0; i < n; i++) applyStimulus(mkIn(1'b0, hs, vs, hi, vi), 1'b0);
    endtask

    task automatic video(input int n);
        for (int i = 0; i < n; i++) applyStimulus(mkIn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
    endtask

    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) applyStimulus(mkIn(1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if ({tmdsCh2, tmdsCh1, tmdsCh0} === e.chars) passes++;
        else $display("[TB] FAIL chars t=%0t got %b_%b_%b want %b_%b_%b", $time,
                      tmdsCh2, tmdsCh1, tmdsCh0,
                      e.chars[29:20], e.chars[19:10], e.chars[9:0]);
        checks++;
        if (collisionError === e.coll) passes++;
        else $display("[TB] FAIL collisionError t=%0t got %b want %b",
                      $time, collisionError, e.coll);
    endtask

    // Monitor: after each rising edge, compare the registered outputs with
    // the oldest expectation that the stimulus side has queued.
    initial begin
        forever begin
            @(posedge pixelClock);
            #1;
            if (expQ.size() > 0) begin
                mon = expQ.pop_front();
                checkOutput(mon);
            end
        end
    end

    // Stimulus: directed corner cases first, then random segments.
    initial begin
        int kind;
        int len;
        int isl;
        logic rhs, rvs;
        checks     = 0;
        passes     = 0;
        cyc        = 16;
        collSticky = 1'b0;
        for (int i = 0; i < HIST; i++) begin
            hist[i] = '0;
            ovr[i]  = 0;
        end
        reset = 1'b1;
        {hSync, vSync, dataEnable, hIslandActive, vIslandActive} = '0;
        {videoCh0, videoCh1, videoCh2, hCh0, hCh1, hCh2, vCh0, vCh1, vCh2} = '0;

        $display("[TB] directed sequences");
        doReset(3);
        blank(40, 1'b0, 1'b0, 1'b0, 1'b0);
        video(20);
        blank(12, 1'b0, 1'b0, 1'b0, 1'b0);
        blank(5, 1'b0, 1'b0, 1'b0, 1'b0);
        blank(36, 1'b0, 1'b0, 1'b1, 1'b0);
        blank(15, 1'b0, 1'b0, 1'b0, 1'b0);
        blank(15, 1'b0, 1'b1, 1'b0, 1'b0);
        blank(8, 1'b1, 1'b1, 1'b0, 1'b1);
        blank(1, 1'b0, 1'b0, 1'b1, 1'b1);
        blank(15, 1'b0, 1'b0, 1'b0, 1'b0);
        doReset(2);
        blank(12, 1'b0, 1'b0, 1'b0, 1'b0);
        video(20);
        blank(6, 1'b0, 1'b0, 1'b0, 1'b0);
        video(20);
        blank(15, 1'b0, 1'b0, 1'b0, 1'b0);
        doReset(2);
        blank(12, 1'b0, 1'b0, 1'b0, 1'b0);
        video(10);
        blank(10, 1'b0, 1'b0, 1'b0, 1'b0);
        video(10);
        blank(9, 1'b0, 1'b0, 1'b0, 1'b0);
        video(5);
        blank(15, 1'b0, 1'b0, 1'b0, 1'b0);
        doReset(2);
        blank(20, 1'b0, 1'b0, 1'b0, 1'b0);
        video(4);
        doReset(1);
        blank(15, 1'b0, 1'b0, 1'b0, 1'b0);
        video(15);
        blank(15, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] random segments");
        for (int seg = 0; seg < 70; seg++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                doReset($urandom_range(1, 3));
            end else if (kind <= 4) begin
                video($urandom_range(1, 30));
            end else begin
                if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 9);
                else                           len = $urandom_range(10, 25);
                isl = $urandom_range(0, 7);
                rhs = 1'($urandom_range(0, 1));
                rvs = 1'($urandom_range(0, 1));
                blank(len, rhs, rvs, (isl == 1 || isl == 2 || isl == 7),
                      (isl == 3 || isl == 7));
            end
        end
        blank(15, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge pixelClock);
        #2;
        if (expQ.size() != 0) begin
            checks++;
            $display("[TB] FAIL drain got %0d pending want 0", expQ.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
